// File: rtl/load_store_unit.sv
// RV32 load/store unit for a single-port word-wide data memory.
// Sub-word stores use read-modify-write; LSU_MISALIGN_CHECK_EN enables misalignment errors.
module load_store_unit #(
    parameter int datawidth = 32,
    parameter int dmemwidth = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [2:0]           req_funct3_i,
    input  logic [31:0]          req_addr_i,
    input  logic [datawidth-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [datawidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [dmemwidth-1:0] dmem_addr_o,
    output logic [datawidth-1:0] dmem_wdata_o,
    output logic                 dmem_wren_o,
    input  logic [datawidth-1:0] dmem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDATA,
        WR,
        RESP
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   we_q;
    logic [2:0]             f3_q;
    logic [1:0]             off_q;
    logic [dmemwidth-1:0]   waddr_q;
    logic [datawidth-1:0]   wdata_q;
    logic [datawidth-1:0]   rdata_q;
    logic                   err_q;

    logic                   accept;
    logic                   f3_legal;
    logic                   misalign;
    logic                   req_err;
    logic [1:0]             req_off;
    logic [7:0]             lane_b;
    logic [15:0]            lane_h;
    logic [datawidth-1:0]   load_val;
    logic [datawidth-1:0]   merged;
    logic                   addr_unused;

    // upper address bits wrap modulo memory size, low bits feed lane select
    assign addr_unused = ^req_addr_i[31:dmemwidth+2];

    assign accept      = req_valid_i && (state == IDLE);
    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    assign dmem_wren_o = (state == WR);
    assign dmem_addr_o = waddr_q;
    assign dmem_wdata_o = wdata_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    // classify the incoming request: legal width/sign, alignment, lane offset
    always_comb begin
        f3_legal = 1'b0;
        misalign = 1'b0;
        req_off  = req_addr_i[1:0];
        case (req_funct3_i)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !req_we_i;
            default:                f3_legal = 1'b0;
        endcase
        case (req_funct3_i[1:0])
            2'b01:   req_off = {req_addr_i[1], 1'b0};
            2'b10:   req_off = 2'b00;
            default: req_off = req_addr_i[1:0];
        endcase
`ifdef LSU_MISALIGN_CHECK_EN
        case (req_funct3_i[1:0])
            2'b01:   misalign = req_addr_i[0];
            2'b10:   misalign = (req_addr_i[1:0] != 2'b00);
            default: misalign = 1'b0;
        endcase
`endif
        req_err = !f3_legal || misalign;
    end

    // extract and extend the load lane, and merge sub-word store data
    always_comb begin
        lane_b   = dmem_rdata_i[{off_q, 3'b000} +: 8];
        lane_h   = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        load_val = dmem_rdata_i;
        merged   = dmem_rdata_i;
        case (f3_q)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_val = {24'h0, lane_b};
            3'b101:  load_val = {16'h0, lane_h};
            default: load_val = dmem_rdata_i;
        endcase
        case (f3_q[1:0])
            2'b00:   merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = dmem_rdata_i;
        endcase
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    // next-state sequencing of the memory access
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = RESP;
                    else if (req_we_i && req_funct3_i == 3'b010)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = RDATA;
            RDATA:   state_next = we_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // request latches, write word and response registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we_i;
                        f3_q    <= req_funct3_i;
                        off_q   <= req_off;
                        waddr_q <= req_addr_i[dmemwidth+1:2];
                        wdata_q <= req_wdata_i;
                        if (req_err) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (we_q) begin
                        wdata_q <= merged;
                    end else begin
                        rdata_q <= load_val;
                        err_q   <= 1'b0;
                    end
                end
                WR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a synchronous word memory model.
// Expectations follow LSU_MISALIGN_CHECK_EN when it is defined.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_wren;
    logic [31:0] dmem_rdata;

    logic [31:0] mem [0:4095];

    int total;
    int bad;

    int          r_cyc;
    int          w_cyc;
    int          w_cnt;
    logic [31:0] w_data;
    logic [31:0] w_addr;
    logic [31:0] r_data;
    logic        r_err;

    load_store_unit #(
        .datawidth(32),
        .dmemwidth(12)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i(req_we),
        .req_funct3_i(req_funct3),
        .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid),
        .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err),
        .dmem_addr_o(dmem_addr),
        .dmem_wdata_o(dmem_wdata),
        .dmem_wren_o(dmem_wren),
        .dmem_rdata_i(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmem_wren) mem[dmem_addr] <= dmem_wdata;
        dmem_rdata <= mem[dmem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic run(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic hold);
        r_cyc  = -1;
        w_cyc  = -1;
        w_cnt  = 0;
        w_data = '0;
        w_addr = '0;
        r_data = '0;
        r_err  = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        if (hold) begin
            req_we     = 1'b1;
            req_funct3 = 3'b010;
            req_addr   = 32'h40;
            req_wdata  = 32'h00000BAD;
        end else begin
            req_valid = 1'b0;
        end
        for (int c = 1; c <= 8; c++) begin
            if (hold && !rsp_valid) check("busy_ready", {31'b0, req_ready}, 32'h0);
            if (dmem_wren) begin
                w_cnt++;
                w_cyc  = c;
                w_data = dmem_wdata;
                w_addr = {20'h0, dmem_addr};
            end
            if (rsp_valid) begin
                r_cyc  = c;
                r_data = rsp_rdata;
                r_err  = rsp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (r_cyc < 0) check("rsp_timeout", 32'hFFFFFFFF, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'h1);
        check("rst_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'b0, rsp_err}, 32'h0);
        check("rst_addr", {20'h0, dmem_addr}, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_wren", {31'b0, dmem_wren}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        check("sw_rsp_cyc", r_cyc, 2);
        check("sw_wr_cyc", w_cyc, 1);
        check("sw_wr_cnt", w_cnt, 1);
        check("sw_addr", w_addr, 32'h4);
        check("sw_data", w_data, 32'hDEADBEEF);
        check("sw_err", {31'b0, r_err}, 32'h0);

        run(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
        check("lb_rsp_cyc", r_cyc, 3);
        check("lb_data", r_data, 32'hFFFFFFDE);
        check("lb_wr_cnt", w_cnt, 0);

        run(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
        check("lbu_data", r_data, 32'h000000DE);

        run(1'b0, 3'b101, 32'h12, 32'h0, 1'b0);
        check("lhu_data", r_data, 32'h0000DEAD);

        run(1'b0, 3'b001, 32'h10, 32'h0, 1'b0);
        check("lh_data", r_data, 32'hFFFFBEEF);

        run(1'b1, 3'b000, 32'h11, 32'h55, 1'b0);
        check("sb_rsp_cyc", r_cyc, 4);
        check("sb_wr_cyc", w_cyc, 3);
        check("sb_data", w_data, 32'hDEAD55EF);
        check("sb_err", {31'b0, r_err}, 32'h0);

        run(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        check("lw_data", r_data, 32'hDEAD55EF);

        run(1'b0, 3'b010, 32'h12, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_CHECK_EN
        check("mis_rsp_cyc", r_cyc, 1);
        check("mis_err", {31'b0, r_err}, 32'h1);
        check("mis_rdata", r_data, 32'h0);
`else
        check("mis_rsp_cyc", r_cyc, 3);
        check("mis_err", {31'b0, r_err}, 32'h0);
        check("mis_rdata", r_data, 32'hDEAD55EF);
`endif
        check("mis_wr_cnt", w_cnt, 0);

        run(1'b1, 3'b100, 32'h10, 32'h12345678, 1'b0);
        check("bad_st_cyc", r_cyc, 1);
        check("bad_st_err", {31'b0, r_err}, 32'h1);
        check("bad_st_rdata", r_data, 32'h0);
        check("bad_st_wr_cnt", w_cnt, 0);
        check("bad_st_mem", mem[4], 32'hDEAD55EF);

        run(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
        check("bad_ld_err", {31'b0, r_err}, 32'h1);

        run(1'b0, 3'b010, 32'h4010, 32'h0, 1'b0);
        check("wrap_data", r_data, 32'hDEAD55EF);

        run(1'b1, 3'b001, 32'h12, 32'h9999ABCD, 1'b0);
        check("sh_data", w_data, 32'hABCD55EF);
        check("sh_rsp_cyc", r_cyc, 4);

        run(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        check("hold_data", r_data, 32'hABCD55EF);
        check("hold_rsp_cyc", r_cyc, 3);
        check("hold_wr_cnt", w_cnt, 0);
        check("hold_mem", mem[16], 32'h0);

        run(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0);
        check("sw2_data", w_data, 32'hCAFEF00D);

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h20;
        req_wdata  = 32'h00001234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_pre_state", {31'b0, req_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'b0, req_ready}, 32'h1);
        check("abort_valid", {31'b0, rsp_valid}, 32'h0);
        check("abort_rdata", rsp_rdata, 32'h0);
        check("abort_err", {31'b0, rsp_err}, 32'h0);
        check("abort_addr", {20'h0, dmem_addr}, 32'h0);
        check("abort_wdata", dmem_wdata, 32'h0);
        check("abort_wren", {31'b0, dmem_wren}, 32'h0);
        @(posedge clk);
        #1;
        check("abort_wren2", {31'b0, dmem_wren}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_no_rsp", {31'b0, rsp_valid}, 32'h0);
        end
        check("abort_mem", mem[8], 32'hCAFEF00D);

        run(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
        check("abort_lw", r_data, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the single-port word-wide data memory (synchronous read, whole-word write, no byte enables). Accepts RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW), drives the memory's address/wdata/wren port, and returns sign- or zero-extended load data. Sub-word stores use a read-modify-write sequence. Sits between the execute stage and the data memory.

## Interface
- datawidth, 32, data word width (fixed at 32 for RV32 lane logic)
- dmemwidth, 12, memory word-address width (2**dmemwidth words)

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted this cycle when valid & ready
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data (low bits used for B/H)
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  illegal funct3 or misaligned access (with response)
- dmem_addr_o  out  dmemwidth  word address = latched addr[dmemwidth+1:2]
- dmem_wdata_o  out  32  write word
- dmem_wren_o  out  1  memory write enable
- dmem_rdata_i  in  32  memory read data, valid the cycle after addr presented with wren low

## Operation
- States: IDLE, RD, RDATA, WR, RESP. req_ready_o = (state == IDLE).
- Accept in IDLE: latch we, funct3, addr, wdata. Next state:
  - error (illegal funct3; store funct3 100/101 illegal; misaligned per Configuration) -> RESP, rsp_err_o=1
  - load or SB/SH -> RD
  - SW -> WR, wdata register = req_wdata_i
- RD: dmem_wren_o=0, address driven -> RDATA.
- RDATA: dmem_rdata_i valid.
  - load: extract lane -> rsp_rdata register; -> RESP
  - SB/SH: merge new byte/half into dmem_rdata_i -> wdata register; -> WR
- WR: dmem_wren_o=1 for exactly one cycle -> RESP.
- RESP: rsp_valid_o=1 one cycle -> IDLE.
- Lane select: byte lane addr[1:0]; half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes word.
- Address bits above dmemwidth+1 ignored (wrap modulo memory size).
- Request inputs sampled only at acceptance; valid while not ready ignored, no queuing.
- dmem_addr_o/dmem_wdata_o driven from latched registers, stable from RD/WR entry through RESP.

## Timing
- Reset (async, immediate): state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, dmem_addr_o=0, dmem_wdata_o=0, dmem_wren_o=0.
- Accept edge = edge 0. Load: RD cycle 1, RDATA cycle 2, rsp_valid_o cycle 3, next accept at edge 4.
- SW: WR cycle 1, RESP cycle 2. SB/SH: RD 1, RDATA 2, WR 3, RESP 4.
- Error: RESP cycle 1, no memory access, dmem_wren_o never asserted.
- rsp_rdata_o/rsp_err_o hold last value outside RESP; only meaningful when rsp_valid_o=1.
- Reset mid-operation aborts: dmem_wren_o drops asynchronously; memory word unchanged unless WR edge already completed; no response issued.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 -> error response, no access.
- Not defined: misaligned addresses force-aligned (H ignores addr[0], W ignores addr[1:0]); rsp_err_o only for illegal funct3.

## Test plan
- Reset then SW addr 0x10 data 0xDEADBEEF -> dmem_wren_o one cycle at cycle 1, dmem_addr_o=4, rsp_valid_o cycle 2, rsp_err_o=0.
- After above, LB addr 0x13 -> rsp_rdata_o=0xFFFFFFDE at cycle 3; LBU addr 0x13 -> 0x000000DE; LHU addr 0x12 -> 0x0000DEAD.
- SB addr 0x11 data 0x55 over 0xDEADBEEF -> RD, RDATA, WR with dmem_wdata_o=0xDEAD55EF, RESP at cycle 4; subsequent LW returns 0xDEAD55EF.
- LW addr 0x12: with LSU_MISALIGN_CHECK_EN -> rsp_err_o=1 at cycle 1, no dmem access; without -> reads word 4 (0xDEAD55EF), rsp_err_o=0.
- Store funct3 100 -> rsp_err_o=1, rsp_rdata_o=0, dmem_wren_o stays 0.
- SH addr 0x20 with rst_ni pulsed low during RDATA -> outputs at reset values immediately, word 8 unchanged, no rsp_valid_o; req_valid_i held during busy states not accepted.
